// File: rtl/ann_layer_sequencer.sv
// ann_layer_sequencer
//   Controller for one fully-connected layer on a shared MAC datapath. For each
//   neuron it clears the accumulator, steps through every input/weight pair,
//   runs the activation unit for ACT_LATENCY cycles, then writes the result to
//   the output memory. It then moves on to the next neuron, and after the last
//   neuron it pulses done.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start / busy / done   handshake with the network controller
//   abort                 synchronous cancel of a running pass
//   in_valid              input feeder has the pair at in_addr ready (ACCUM stall)
//   out_ready             output memory accepts the write (WRITE stall)
//   mac_clr/mac_en/act_en MAC datapath strobes
//   out_we                output memory write request at out_addr
//   in_addr / out_addr    current input index / neuron index
//
// Optional build macro ANN_SEQ_PERF_EN adds perf_cycles (busy cycles) and
// perf_stalls (ACCUM cycles without in_valid plus WRITE cycles without
// out_ready). Both saturate, and both clear on reset and on each accepted start.

module ann_layer_sequencer #(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_NEURONS = 4,
  parameter int ACT_LATENCY = 2,
  localparam int NI_W = (NUM_INPUTS  > 1) ? $clog2(NUM_INPUTS)  : 1,
  localparam int NN_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            in_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            done,
  output logic            mac_clr,
  output logic            mac_en,
  output logic            act_en,
  output logic            out_we,
  output logic [NI_W-1:0] in_addr,
  output logic [NN_W-1:0] out_addr
`ifdef ANN_SEQ_PERF_EN
  ,
  output logic [31:0]     perf_cycles,
  output logic [31:0]     perf_stalls
`endif
);

  localparam int AC_W = (ACT_LATENCY > 1) ? $clog2(ACT_LATENCY) : 1;

  typedef enum logic [2:0] {
    IDLE, CLEAR, ACCUM, ACT, WRITE, DONE
  } state_t;

  state_t          state, state_nxt;
  logic [AC_W-1:0] act_cnt;

  logic last_in, last_n, act_last, kill;

  assign last_in  = (in_addr  == NI_W'(NUM_INPUTS - 1));
  assign last_n   = (out_addr == NN_W'(NUM_NEURONS - 1));
  assign act_last = (act_cnt  == AC_W'(ACT_LATENCY - 1));
  // abort only matters once a pass is running; in IDLE start takes precedence
  assign kill     = abort && (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   state_nxt = ACCUM;
      ACCUM:   if (in_valid && last_in) state_nxt = ACT;
      ACT:     if (act_last) state_nxt = WRITE;
      WRITE:   if (out_ready) state_nxt = last_n ? DONE : CLEAR;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  // Index and activation counters. The activation counter is zeroed while in
  // ACCUM so it is always 0 on entry to ACT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_addr  <= '0;
      out_addr <= '0;
      act_cnt  <= '0;
    end else if (kill) begin
      in_addr  <= '0;
      out_addr <= '0;
      act_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          in_addr  <= '0;
          out_addr <= '0;
          act_cnt  <= '0;
        end
        ACCUM: begin
          act_cnt <= '0;
          if (in_valid) in_addr <= last_in ? '0 : in_addr + 1'b1;
        end
        ACT:   act_cnt <= act_last ? '0 : act_cnt + 1'b1;
        WRITE: if (out_ready) out_addr <= last_n ? '0 : out_addr + 1'b1;
        default: ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    busy    = (state != IDLE);
    done    = (state == DONE);
    mac_clr = (state == CLEAR);
    mac_en  = (state == ACCUM) && in_valid;
    act_en  = (state == ACT);
    out_we  = (state == WRITE);
  end

`ifdef ANN_SEQ_PERF_EN
  logic stall;
  assign stall = ((state == ACCUM) && !in_valid) || ((state == WRITE) && !out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        perf_cycles <= '0;
        perf_stalls <= '0;
      end
    end else begin
      if (perf_cycles != '1)          perf_cycles <= perf_cycles + 1'b1;
      if (stall && perf_stalls != '1) perf_stalls <= perf_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ann_layer_sequencer.sv
module tb_ann_layer_sequencer;

  localparam int NI = 4;
  localparam int NN = 4;
  localparam int AL = 2;

  // step kinds of the reference schedule
  localparam int K_C = 0;
  localparam int K_A = 1;
  localparam int K_T = 2;
  localparam int K_W = 3;
  localparam int K_D = 4;

  typedef struct {
    int kind;
    int ii;
    int nn;
  } step_t;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, in_valid, out_ready;
  logic       busy, done, mac_clr, mac_en, act_en, out_we;
  logic [1:0] in_addr, out_addr;

  logic       s_start;
  logic       s_busy, s_done, s_mac_clr, s_mac_en, s_act_en, s_out_we;
  logic [0:0] s_in_addr, s_out_addr;

`ifdef ANN_SEQ_PERF_EN
  logic [31:0] perf_cycles, perf_stalls, s_perf_cycles, s_perf_stalls;
`endif

  always #5 clk = ~clk;

  ann_layer_sequencer #(
    .NUM_INPUTS(NI), .NUM_NEURONS(NN), .ACT_LATENCY(AL)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .mac_clr(mac_clr), .mac_en(mac_en),
    .act_en(act_en), .out_we(out_we), .in_addr(in_addr), .out_addr(out_addr)
`ifdef ANN_SEQ_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
  );

  ann_layer_sequencer #(
    .NUM_INPUTS(1), .NUM_NEURONS(1), .ACT_LATENCY(1)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(1'b0),
    .in_valid(1'b1), .out_ready(1'b1),
    .busy(s_busy), .done(s_done), .mac_clr(s_mac_clr), .mac_en(s_mac_en),
    .act_en(s_act_en), .out_we(s_out_we), .in_addr(s_in_addr), .out_addr(s_out_addr)
`ifdef ANN_SEQ_PERF_EN
    , .perf_cycles(s_perf_cycles), .perf_stalls(s_perf_stalls)
`endif
  );

  int total = 0;
  int bad   = 0;

  step_t q[$];
  int    e_pc, e_ps;
  int    cyc_no;
  int    obs_busy, obs_done, done_at, we_n;
  int    we_cyc[$];
  int    we_adr[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Whole pass as a flat list of steps; a stall simply keeps the head in place.
  task automatic fill_pass();
    step_t s;
    for (int n = 0; n < NN; n++) begin
      s = '{K_C, 0, n}; q.push_back(s);
      for (int i = 0; i < NI; i++) begin s = '{K_A, i, n}; q.push_back(s); end
      for (int t = 0; t < AL; t++) begin s = '{K_T, 0, n}; q.push_back(s); end
      s = '{K_W, 0, n}; q.push_back(s);
    end
    s = '{K_D, 0, 0}; q.push_back(s);
  endtask

  task automatic clr_obs();
    obs_busy = 0; obs_done = 0; done_at = -1; we_n = 0;
    we_cyc.delete(); we_adr.delete();
  endtask

  task automatic cyc(input logic v, input logic r, input logic s, input logic a);
    int    k;
    step_t h;
    logic  e_busy, e_done, e_clr, e_mac, e_act, e_we;
    int    e_in, e_out;
    @(negedge clk);
    in_valid = v; out_ready = r; start = s; abort = a;
    #1;
    cyc_no++;
    k = -1; h = '{0, 0, 0};
    if (q.size() > 0) begin h = q[0]; k = h.kind; end
    e_busy = (k >= 0);
    e_done = (k == K_D);
    e_clr  = (k == K_C);
    e_mac  = (k == K_A) && v;
    e_act  = (k == K_T);
    e_we   = (k == K_W);
    e_in   = (k == K_A) ? h.ii : 0;
    e_out  = (k >= 0 && k != K_D) ? h.nn : 0;
    check("busy",     {31'b0, busy},    {31'b0, e_busy});
    check("done",     {31'b0, done},    {31'b0, e_done});
    check("mac_clr",  {31'b0, mac_clr}, {31'b0, e_clr});
    check("mac_en",   {31'b0, mac_en},  {31'b0, e_mac});
    check("act_en",   {31'b0, act_en},  {31'b0, e_act});
    check("out_we",   {31'b0, out_we},  {31'b0, e_we});
    check("in_addr",  {30'b0, in_addr}, e_in);
    check("out_addr", {30'b0, out_addr}, e_out);
`ifdef ANN_SEQ_PERF_EN
    check("perf_cycles", perf_cycles, e_pc);
    check("perf_stalls", perf_stalls, e_ps);
`endif
    if (busy) obs_busy++;
    if (done) begin obs_done++; done_at = cyc_no; end
    if (out_we && r) begin we_n++; we_cyc.push_back(cyc_no); we_adr.push_back(int'(out_addr)); end
    // advance the reference to what the next clock edge produces
    if (k < 0) begin
      if (s) begin fill_pass(); e_pc = 0; e_ps = 0; cyc_no = 0; end
    end else begin
      e_pc++;
      if ((k == K_A && !v) || (k == K_W && !r)) e_ps++;
      if (a) q.delete();
      else if (!((k == K_A && !v) || (k == K_W && !r))) void'(q.pop_front());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    q.delete(); e_pc = 0; e_ps = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    s_start = 1'b0;
    e_pc = 0; e_ps = 0; cyc_no = 0;
    clr_obs();
    #12;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_in_addr", {30'b0, in_addr}, 0);
    check("rst_out_addr", {30'b0, out_addr}, 0);
    check("rst_strobes", {26'b0, done, mac_clr, mac_en, act_en, out_we, s_busy}, 0);
    @(negedge clk); rst_n = 1'b1;

    // unstalled pass
    cyc(1, 1, 1, 0); clr_obs();
    for (int c = 1; c <= 36; c++) cyc(1, 1, 0, 0);
    check("t1_busy_len", obs_busy, 33);
    check("t1_done_at", done_at, 33);
    check("t1_we_n", we_n, NN);
    for (int n = 0; n < NN && n < we_n; n++) begin
      check("t1_we_cyc", we_cyc[n], 8 * (n + 1));
      check("t1_we_adr", we_adr[n], n);
    end

    // feeder stall: in_addr=2 of neuron 1 sits at cycles 12..14
    do_reset();
    cyc(1, 1, 1, 0); clr_obs();
    for (int c = 1; c <= 40; c++) cyc((c >= 12 && c <= 14) ? 1'b0 : 1'b1, 1, 0, 0);
    check("t2_done_at", done_at, 36);
    check("t2_busy_len", obs_busy, 36);
`ifdef ANN_SEQ_PERF_EN
    check("t2_perf_cycles", perf_cycles, 36);
    check("t2_perf_stalls", perf_stalls, 3);
`endif

    // output memory stall on neuron 3 write
    do_reset();
    cyc(1, 1, 1, 0); clr_obs();
    for (int c = 1; c <= 42; c++) cyc(1, (c >= 32 && c <= 36) ? 1'b0 : 1'b1, 0, 0);
    check("t3_done_at", done_at, 38);
    check("t3_we_n", we_n, NN);

    // start while busy, then held through DONE into a second pass
    do_reset();
    cyc(1, 1, 1, 0); clr_obs();
    for (int c = 1; c <= 34; c++) cyc(1, 1, (c == 5 || c == 6 || c >= 30) ? 1'b1 : 1'b0, 0);
    for (int c = 1; c <= 36; c++) cyc(1, 1, 0, 0);
    check("t4_done_cnt", obs_done, 2);
    check("t4_busy_len", obs_busy, 66);

    // abort during ACT of neuron 2, then a fresh full pass
    do_reset();
    cyc(1, 1, 1, 0); clr_obs();
    for (int c = 1; c <= 26; c++) cyc(1, 1, 0, (c == 22) ? 1'b1 : 1'b0);
    check("t5_done_cnt", obs_done, 0);
    check("t5_we_n", we_n, 2);
    cyc(1, 1, 1, 0); clr_obs();
    for (int c = 1; c <= 36; c++) cyc(1, 1, 0, 0);
    check("t5_busy_len", obs_busy, 33);
    check("t5_done_at", done_at, 33);

    // randomized traffic against the reference schedule
    do_reset();
    for (int c = 0; c < 600; c++)
      cyc($urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0,
          $urandom_range(7, 0) == 0, $urandom_range(63, 0) == 0);

    // asynchronous reset in the middle of ACCUM
    do_reset();
    cyc(1, 1, 1, 0);
    for (int c = 1; c <= 3; c++) cyc(1, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 0);
    check("arst_in_addr", {30'b0, in_addr}, 0);
    check("arst_out_addr", {30'b0, out_addr}, 0);
    check("arst_strobes", {27'b0, done, mac_clr, mac_en, act_en, out_we}, 0);
    q.delete(); e_pc = 0; e_ps = 0;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 4; c++) cyc(1, 1, 0, 0);

    // single input / single neuron / single activation cycle build
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      check("small_busy",   {31'b0, s_busy},    (k <= 5) ? 1 : 0);
      check("small_clr",    {31'b0, s_mac_clr}, (k == 1) ? 1 : 0);
      check("small_mac",    {31'b0, s_mac_en},  (k == 2) ? 1 : 0);
      check("small_act",    {31'b0, s_act_en},  (k == 3) ? 1 : 0);
      check("small_we",     {31'b0, s_out_we},  (k == 4) ? 1 : 0);
      check("small_done",   {31'b0, s_done},    (k == 5) ? 1 : 0);
      check("small_in_addr", {31'b0, s_in_addr}, 0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
